// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - LC3 fetch, data and preload port bundle
interface lc3_mem_responder_if;
   logic [15:0] pc;
   logic        instrmem_rd;
   logic [15:0] Instr_dout;
   logic        complete_instr;
   logic        data_en;
   logic [15:0] Data_addr;
   logic        Data_rd;
   logic [15:0] Data_din;
   logic [15:0] Data_dout;
   logic        complete_data;
   logic        load_en;
   logic        load_sel;
   logic [15:0] load_addr;
   logic [15:0] load_data;

   modport master (
      output pc, instrmem_rd, data_en, Data_addr, Data_rd, Data_din,
             load_en, load_sel, load_addr, load_data,
      input  Instr_dout, complete_instr, Data_dout, complete_data
   );

   modport slave (
      input  pc, instrmem_rd, data_en, Data_addr, Data_rd, Data_din,
             load_en, load_sel, load_addr, load_data,
      output Instr_dout, complete_instr, Data_dout, complete_data
   );
endinterface

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - IMEM/DMEM responder with programmable wait states
// The array is read at the edge entering RESP; the complete pulse and dout follow one edge later.
module lc3_mem_responder #(
   parameter int AW    = 8,
   parameter int I_LAT = 0,
   parameter int D_LAT = 0
) (
   input  logic                clock,
   input  logic                reset,
   lc3_mem_responder_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   localparam logic [2:0] I_CNT0 = 3'((I_LAT > 0) ? I_LAT - 1 : 0);
   localparam logic [2:0] D_CNT0 = 3'((D_LAT > 0) ? D_LAT - 1 : 0);

   logic [15:0] r_imem [0:(1<<AW)-1];
   logic [15:0] r_dmem [0:(1<<AW)-1];

   state_t          r_i_state, w_i_state_nx;
   logic [2:0]      r_i_cnt, w_i_cnt_nx;
   logic [AW-1:0]   r_i_addr;
   logic [15:0]     r_i_rdata, r_i_dout;
   logic            r_i_done, w_i_cap, w_i_enter;
   logic [AW-1:0]   w_i_addr;

   state_t          r_d_state, w_d_state_nx;
   logic [2:0]      r_d_cnt, w_d_cnt_nx;
   logic [AW-1:0]   r_d_addr;
   logic            r_d_rd;
   logic [15:0]     r_d_din, r_d_rdata, r_d_dout;
   logic            r_d_done, w_d_cap, w_d_enter, w_d_rd;
   logic [AW-1:0]   w_d_addr;
   logic [15:0]     w_d_din;

   logic w_unused_bits;
   assign w_unused_bits = ^{bus.pc[15:AW], bus.Data_addr[15:AW], bus.load_addr[15:AW]};

   always_comb begin
      w_i_state_nx = r_i_state;
      w_i_cnt_nx   = r_i_cnt;
      w_i_cap      = 1'b0;
      case (r_i_state)
         S_WAIT: begin
            if (r_i_cnt == 3'd0) w_i_state_nx = S_RESP;
            else                 w_i_cnt_nx   = r_i_cnt - 3'd1;
         end
         default: begin
            w_i_state_nx = S_IDLE;
            if (bus.instrmem_rd) begin
               w_i_cap = 1'b1;
               if (I_LAT == 0) begin
                  w_i_state_nx = S_RESP;
               end else begin
                  w_i_state_nx = S_WAIT;
                  w_i_cnt_nx   = I_CNT0;
               end
            end
         end
      endcase
   end

   assign w_i_enter = (w_i_state_nx == S_RESP);
   assign w_i_addr  = w_i_cap ? bus.pc[AW-1:0] : r_i_addr;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_i_state <= S_IDLE;
         r_i_cnt   <= 3'd0;
         r_i_addr  <= '0;
         r_i_rdata <= 16'h0000;
         r_i_dout  <= 16'h0000;
         r_i_done  <= 1'b0;
      end else begin
         r_i_state <= w_i_state_nx;
         r_i_cnt   <= w_i_cnt_nx;
         r_i_done  <= (r_i_state == S_RESP);
         if (w_i_cap)              r_i_addr  <= bus.pc[AW-1:0];
         if (w_i_enter)            r_i_rdata <= r_imem[w_i_addr];
         if (r_i_state == S_RESP)  r_i_dout  <= r_i_rdata;
      end
   end

   always_comb begin
      w_d_state_nx = r_d_state;
      w_d_cnt_nx   = r_d_cnt;
      w_d_cap      = 1'b0;
      case (r_d_state)
         S_WAIT: begin
            if (r_d_cnt == 3'd0) w_d_state_nx = S_RESP;
            else                 w_d_cnt_nx   = r_d_cnt - 3'd1;
         end
         default: begin
            w_d_state_nx = S_IDLE;
            if (bus.data_en) begin
               w_d_cap = 1'b1;
               if (D_LAT == 0) begin
                  w_d_state_nx = S_RESP;
               end else begin
                  w_d_state_nx = S_WAIT;
                  w_d_cnt_nx   = D_CNT0;
               end
            end
         end
      endcase
   end

   assign w_d_enter = (w_d_state_nx == S_RESP);
   assign w_d_addr  = w_d_cap ? bus.Data_addr[AW-1:0] : r_d_addr;
   assign w_d_rd    = w_d_cap ? bus.Data_rd : r_d_rd;
   assign w_d_din   = w_d_cap ? bus.Data_din : r_d_din;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_d_state <= S_IDLE;
         r_d_cnt   <= 3'd0;
         r_d_addr  <= '0;
         r_d_rd    <= 1'b0;
         r_d_din   <= 16'h0000;
         r_d_rdata <= 16'h0000;
         r_d_dout  <= 16'h0000;
         r_d_done  <= 1'b0;
      end else begin
         r_d_state <= w_d_state_nx;
         r_d_cnt   <= w_d_cnt_nx;
         r_d_done  <= (r_d_state == S_RESP);
         if (w_d_cap) begin
            r_d_addr <= bus.Data_addr[AW-1:0];
            r_d_rd   <= bus.Data_rd;
            r_d_din  <= bus.Data_din;
         end
         if (w_d_enter && w_d_rd)           r_d_rdata <= r_dmem[w_d_addr];
         if (r_d_state == S_RESP && r_d_rd) r_d_dout  <= r_d_rdata;
      end
   end

   // Arrays survive reset; the D-write comes last so it beats a same-edge preload.
   always_ff @(posedge clock) begin
      if (bus.load_en) begin
         if (bus.load_sel) r_dmem[bus.load_addr[AW-1:0]] <= bus.load_data;
         else              r_imem[bus.load_addr[AW-1:0]] <= bus.load_data;
      end
      if (reset && w_d_enter && !w_d_rd) r_dmem[w_d_addr] <= w_d_din;
   end

   assign bus.Instr_dout     = r_i_dout;
   assign bus.complete_instr = r_i_done;
   assign bus.Data_dout      = r_d_dout;
   assign bus.complete_data  = r_d_done;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - randomized self-checking bench against an array/latency model
// Instance a: I_LAT=0, D_LAT=5. Instance b: I_LAT=3, D_LAT=2.
module tb_lc3_mem_responder;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   lc3_mem_responder_if if_a ();
   lc3_mem_responder_if if_b ();

   lc3_mem_responder #(.AW(8), .I_LAT(0), .D_LAT(5)) u_a (.clock(clock), .reset(reset), .bus(if_a.slave));
   lc3_mem_responder #(.AW(8), .I_LAT(3), .D_LAT(2)) u_b (.clock(clock), .reset(reset), .bus(if_b.slave));

   int checks = 0;
   int passed = 0;

   logic [15:0] m_imem [2][256];
   logic [15:0] m_dmem [2][256];
   logic [15:0] m_idout [2];
   logic [15:0] m_ddout [2];
   int          lat_i [2] = '{0, 3};
   int          lat_d [2] = '{5, 2};

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drv_fetch(input int s, input logic rd, input logic [15:0] a);
      if (s == 0) begin if_a.instrmem_rd = rd; if_a.pc = a; end
      else        begin if_b.instrmem_rd = rd; if_b.pc = a; end
   endtask

   task automatic drv_data(input int s, input logic en, input logic rd, input logic [15:0] a, input logic [15:0] d);
      if (s == 0) begin if_a.data_en = en; if_a.Data_rd = rd; if_a.Data_addr = a; if_a.Data_din = d; end
      else        begin if_b.data_en = en; if_b.Data_rd = rd; if_b.Data_addr = a; if_b.Data_din = d; end
   endtask

   task automatic drv_load(input int s, input logic en, input logic sel, input logic [15:0] a, input logic [15:0] d);
      if (s == 0) begin if_a.load_en = en; if_a.load_sel = sel; if_a.load_addr = a; if_a.load_data = d; end
      else        begin if_b.load_en = en; if_b.load_sel = sel; if_b.load_addr = a; if_b.load_data = d; end
   endtask

   function automatic logic get_ci(input int s);
      return (s == 0) ? if_a.complete_instr : if_b.complete_instr;
   endfunction
   function automatic logic [15:0] get_id(input int s);
      return (s == 0) ? if_a.Instr_dout : if_b.Instr_dout;
   endfunction
   function automatic logic get_cd(input int s);
      return (s == 0) ? if_a.complete_data : if_b.complete_data;
   endfunction
   function automatic logic [15:0] get_dd(input int s);
      return (s == 0) ? if_a.Data_dout : if_b.Data_dout;
   endfunction

   task automatic preload(input int s, input logic sel, input logic [15:0] a, input logic [15:0] d);
      drv_load(s, 1'b1, sel, a, d);
      tick();
      drv_load(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
      if (sel) m_dmem[s][a[7:0]] = d;
      else     m_imem[s][a[7:0]] = d;
   endtask

   task automatic do_fetch(input int s, input logic [15:0] a);
      logic [15:0] exp_w;
      exp_w = m_imem[s][a[7:0]];
      drv_fetch(s, 1'b1, a);
      tick();
      drv_fetch(s, 1'b0, 16'($urandom));
      for (int t = 1; t <= lat_i[s] + 1; t++) begin
         tick();
         checks++;
         if (get_ci(s) !== (t == lat_i[s] + 1))
            $display("FAIL fetch_complete inst%0d pc=%h t=%0d: got %b want %b", s, a, t, get_ci(s), (t == lat_i[s] + 1));
         else passed++;
      end
      checks++;
      if (get_id(s) !== exp_w) $display("FAIL fetch_data inst%0d pc=%h: got %h want %h", s, a, get_id(s), exp_w);
      else passed++;
      m_idout[s] = exp_w;
      tick();
      checks++;
      if (get_ci(s) !== 1'b0 || get_id(s) !== m_idout[s])
         $display("FAIL fetch_hold inst%0d: got c=%b d=%h want c=0 d=%h", s, get_ci(s), get_id(s), m_idout[s]);
      else passed++;
   endtask

   task automatic do_data(input int s, input logic [15:0] a, input logic rd, input logic [15:0] din);
      logic [15:0] exp_d;
      exp_d = rd ? m_dmem[s][a[7:0]] : m_ddout[s];
      drv_data(s, 1'b1, rd, a, din);
      tick();
      drv_data(s, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      for (int t = 1; t <= lat_d[s] + 1; t++) begin
         tick();
         checks++;
         if (get_cd(s) !== (t == lat_d[s] + 1))
            $display("FAIL data_complete inst%0d addr=%h rd=%b t=%0d: got %b want %b", s, a, rd, t, get_cd(s), (t == lat_d[s] + 1));
         else passed++;
      end
      checks++;
      if (get_dd(s) !== exp_d) $display("FAIL data_dout inst%0d addr=%h rd=%b: got %h want %h", s, a, rd, get_dd(s), exp_d);
      else passed++;
      m_ddout[s] = exp_d;
      if (!rd) m_dmem[s][a[7:0]] = din;
      tick();
      checks++;
      if (get_cd(s) !== 1'b0) $display("FAIL data_pulse inst%0d: got %b want 0", s, get_cd(s));
      else passed++;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      drv_fetch(0, 1'b1, 16'h0001); drv_fetch(1, 1'b1, 16'h0002);
      drv_data(0, 1'b1, 1'b1, 16'h0003, 16'h0); drv_data(1, 1'b1, 1'b0, 16'h0004, 16'h1111);
      for (int t = 0; t < 3; t++) begin
         tick();
         for (int s = 0; s < 2; s++) begin
            checks++;
            if ({get_ci(s), get_cd(s), get_id(s), get_dd(s)} !== 34'h0)
               $display("FAIL reset_state inst%0d: got ci=%b cd=%b id=%h dd=%h want all 0", s, get_ci(s), get_cd(s), get_id(s), get_dd(s));
            else passed++;
         end
      end
      for (int s = 0; s < 2; s++) begin
         drv_fetch(s, 1'b0, 16'h0); drv_data(s, 1'b0, 1'b0, 16'h0, 16'h0);
         m_idout[s] = 16'h0; m_ddout[s] = 16'h0;
      end
      tick();
      reset = 1'b1;
   endtask

   task automatic init_arrays;
      for (int sel = 0; sel < 2; sel++)
         for (int i = 0; i < 256; i++) begin
            for (int s = 0; s < 2; s++) begin
               logic [15:0] v;
               v = 16'($urandom);
               drv_load(s, 1'b1, sel[0], 16'(i), v);
               if (sel == 1) m_dmem[s][i] = v; else m_imem[s][i] = v;
            end
            tick();
         end
      drv_load(0, 1'b0, 1'b0, 16'h0, 16'h0);
      drv_load(1, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic test_stream;
      logic [15:0] w [3];
      w[0] = 16'h1261; w[1] = 16'h5020; w[2] = 16'h0E02;
      for (int k = 0; k < 3; k++) preload(0, 1'b0, 16'h3000 + 16'(k), w[k]);
      drv_fetch(0, 1'b1, 16'h3000);
      tick();
      for (int k = 1; k <= 3; k++) begin
         if (k < 3) drv_fetch(0, 1'b1, 16'h3000 + 16'(k));
         else       drv_fetch(0, 1'b0, 16'h0);
         tick();
         checks++;
         if (get_ci(0) !== 1'b1 || get_id(0) !== w[k-1])
            $display("FAIL stream_%0d: got c=%b d=%h want c=1 d=%h", k - 1, get_ci(0), get_id(0), w[k-1]);
         else passed++;
      end
      tick();
      checks++;
      if (get_ci(0) !== 1'b0 || get_id(0) !== w[2])
         $display("FAIL stream_end: got c=%b d=%h want c=0 d=%h", get_ci(0), get_id(0), w[2]);
      else passed++;
      m_idout[0] = w[2];
   endtask

   task automatic test_wait;
      preload(1, 1'b0, 16'h0005, 16'($urandom));
      do_fetch(1, 16'h0005);
   endtask

   task automatic test_write_read;
      do_data(1, 16'h0040, 1'b0, 16'hBEEF);
      do_data(1, 16'h0040, 1'b1, 16'h0000);
   endtask

   task automatic test_wrap;
      preload(1, 1'b1, 16'h0010, 16'h1234);
      do_data(1, 16'h0110, 1'b1, 16'h0000);
   endtask

   task automatic test_collision;
      drv_data(1, 1'b1, 1'b0, 16'h0077, 16'hC0DE);
      tick();
      drv_data(1, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      drv_load(1, 1'b1, 1'b1, 16'h0077, 16'h7777);
      tick();
      drv_load(1, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      checks++;
      if (get_cd(1) !== 1'b1) $display("FAIL collide_complete: got %b want 1", get_cd(1));
      else passed++;
      tick();
      m_dmem[1][8'h77] = 16'hC0DE;
      do_data(1, 16'h0077, 1'b1, 16'h0000);
   endtask

   task automatic test_reset_mid_write;
      preload(0, 1'b1, 16'h0020, 16'h5555);
      drv_data(0, 1'b1, 1'b0, 16'h0020, 16'hAAAA);
      tick();
      drv_data(0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin m_idout[s] = 16'h0; m_ddout[s] = 16'h0; end
      for (int t = 0; t < 8; t++) begin
         checks++;
         if (get_cd(0) !== 1'b0 || get_dd(0) !== 16'h0)
            $display("FAIL abort_write t=%0d: got c=%b d=%h want c=0 d=0000", t, get_cd(0), get_dd(0));
         else passed++;
         tick();
      end
      do_data(0, 16'h0020, 1'b1, 16'h0000);
   endtask

   task automatic test_random;
      for (int n = 0; n < 30; n++) begin
         int s;
         logic [15:0] a;
         s = int'($urandom_range(0, 1));
         a = 16'($urandom);
         case ($urandom_range(0, 3))
            0: preload(s, 1'($urandom), a, 16'($urandom));
            1: do_fetch(s, a);
            2: do_data(s, a, 1'b1, 16'h0000);
            default: do_data(s, a, 1'b0, 16'($urandom));
         endcase
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         drv_fetch(s, 1'b0, 16'h0);
         drv_data(s, 1'b0, 1'b0, 16'h0, 16'h0);
         drv_load(s, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      test_reset();
      init_arrays();
      test_stream();
      test_wait();
      test_write_read();
      test_wrap();
      test_collision();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
